// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_chain
//  Purpose  : Parametrised pipeline-register chain carrying a payload word,
//             a destination-register tag and a write-enable through DEPTH
//             stages. Supports per-stage stall and clear, stall propagation
//             towards younger stages, bubble insertion, a youngest-first
//             forwarding lookup, an occupancy count and a saturating flush
//             counter.
//  Ports    : clk, reset (async, active-low)
//             in_valid/in_data/in_tag/in_we -> stage 0, in_ready = ~hold[0]
//             stall[DEPTH], clear[DEPTH]    -> per-stage hold / flush
//             stage_valid/data/tag/we       -> flattened per-stage contents
//             out_valid/data/tag/we         -> copy of stage DEPTH-1
//             q_addr -> q_hit/q_data/q_stage (combinational forwarding)
//             occ (registered valid count), flush_cnt (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [TAGW-1:0]        in_tag,
  input  logic                   in_we,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       clear,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH*TAGW-1:0]  stage_tag,
  output logic [DEPTH-1:0]       stage_we,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAGW-1:0]        out_tag,
  output logic                   out_we,
  input  logic [TAGW-1:0]        q_addr,
  output logic                   q_hit,
  output logic [WIDTH-1:0]       q_data,
  output logic [2:0]             q_stage,
  output logic [3:0]             occ,
  output logic [15:0]            flush_cnt
);

  // Stage registers, flattened so stage i-1 feeds stage i by a plain shift.
  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_we;
  logic [DEPTH*WIDTH-1:0] r_data;
  logic [DEPTH*TAGW-1:0]  r_tag;
  logic [3:0]             r_occ;
  logic [15:0]            r_flush_cnt;

  logic [DEPTH-1:0]       w_hold;
  logic [DEPTH-1:0]       w_prev_hold;
  logic [DEPTH-1:0]       w_prev_valid;
  logic [DEPTH-1:0]       w_prev_we;
  logic [DEPTH*WIDTH-1:0] w_prev_data;
  logic [DEPTH*TAGW-1:0]  w_prev_tag;
  logic [DEPTH-1:0]       w_nvalid;
  logic [DEPTH-1:0]       w_nwe;
  logic [DEPTH*WIDTH-1:0] w_ndata;
  logic [DEPTH*TAGW-1:0]  w_ntag;
  logic [3:0]             w_nocc;
  logic [3:0]             w_flush_add;
  logic [16:0]            w_flush_sum;
  logic [15:0]            w_nflush_cnt;

  // A stall on any older stage freezes this one too: suffix-OR of stall.
  always_comb begin : hold_calc
    logic acc;
    acc    = 1'b0;
    w_hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc       = acc | stall[i];
      w_hold[i] = acc;
    end
  end

  // Source of each stage: stage 0 reads the input port, others the stage
  // below. Stage 0 never sees a held predecessor, so it never bubbles.
  assign w_prev_hold  = {w_hold[DEPTH-2:0], 1'b0};
  assign w_prev_valid = {r_valid[DEPTH-2:0], in_valid};
  assign w_prev_we    = {r_we[DEPTH-2:0], in_we};
  assign w_prev_data  = {r_data[(DEPTH-1)*WIDTH-1:0], in_data};
  assign w_prev_tag   = {r_tag[(DEPTH-1)*TAGW-1:0], in_tag};

  always_comb begin
    w_nvalid = '0;
    w_nwe    = '0;
    w_ndata  = '0;
    w_ntag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (clear[i]) begin
        // flushed: stays all-zero
      end else if (w_hold[i]) begin
        w_nvalid[i]                = r_valid[i];
        w_nwe[i]                   = r_we[i];
        w_ndata[i*WIDTH +: WIDTH]  = r_data[i*WIDTH +: WIDTH];
        w_ntag[i*TAGW +: TAGW]     = r_tag[i*TAGW +: TAGW];
      end else if (w_prev_hold[i]) begin
        // bubble: stays all-zero
      end else begin
        w_nvalid[i]                = w_prev_valid[i];
        w_nwe[i]                   = w_prev_we[i];
        w_ndata[i*WIDTH +: WIDTH]  = w_prev_data[i*WIDTH +: WIDTH];
        w_ntag[i*TAGW +: TAGW]     = w_prev_tag[i*TAGW +: TAGW];
      end
    end
  end

  // Occupancy tracks next-state valids; flush count adds discarded entries.
  always_comb begin
    w_nocc      = '0;
    w_flush_add = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nocc      = w_nocc + {3'b000, w_nvalid[i]};
      w_flush_add = w_flush_add + {3'b000, clear[i] & r_valid[i]};
    end
    w_flush_sum  = {1'b0, r_flush_cnt} + {13'b0, w_flush_add};
    w_nflush_cnt = w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= '0;
      r_we        <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_occ       <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_valid     <= w_nvalid;
      r_we        <= w_nwe;
      r_data      <= w_ndata;
      r_tag       <= w_ntag;
      r_occ       <= w_nocc;
      r_flush_cnt <= w_nflush_cnt;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit   = 1'b0;
    q_data  = '0;
    q_stage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_we[i] && (q_addr != '0) &&
          (r_tag[i*TAGW +: TAGW] == q_addr)) begin
        q_hit   = 1'b1;
        q_data  = r_data[i*WIDTH +: WIDTH];
        q_stage = 3'(i);
      end
    end
  end

  assign in_ready    = ~w_hold[0];
  assign stage_valid = r_valid;
  assign stage_we    = r_valid & r_we;
  assign stage_data  = r_data;
  assign stage_tag   = r_tag;
  assign out_valid   = r_valid[DEPTH-1];
  assign out_we      = r_valid[DEPTH-1] & r_we[DEPTH-1];
  assign out_data    = r_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign out_tag     = r_tag[(DEPTH-1)*TAGW +: TAGW];
  assign occ         = r_occ;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_chain
//  Purpose  : Directed self-checking bench for pipe_stage_chain (DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAGW  = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [TAGW-1:0]        in_tag;
  logic                   in_we;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       clear;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [DEPTH*TAGW-1:0]  stage_tag;
  logic [DEPTH-1:0]       stage_we;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [TAGW-1:0]        out_tag;
  logic                   out_we;
  logic [TAGW-1:0]        q_addr;
  logic                   q_hit;
  logic [WIDTH-1:0]       q_data;
  logic [2:0]             q_stage;
  logic [3:0]             occ;
  logic [15:0]            flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag), .in_we(in_we),
    .in_ready(in_ready), .stall(stall), .clear(clear),
    .stage_valid(stage_valid), .stage_data(stage_data), .stage_tag(stage_tag),
    .stage_we(stage_we), .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .out_we(out_we), .q_addr(q_addr), .q_hit(q_hit),
    .q_data(q_data), .q_stage(q_stage), .occ(occ), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_tag   = '0;
    in_we    = 1'b0;
    stall    = '0;
    clear    = '0;
    q_addr   = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] t, input logic we);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    in_we    = we;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state and streaming ----------------
    do_reset();
    check("rst_valid", 32'(stage_valid), 32'h0);
    check("rst_occ",   32'(occ),         32'h0);
    check("rst_flush", 32'(flush_cnt),   32'h0);
    check("rst_qhit",  32'(q_hit),       32'h0);
    check("rst_ready", 32'(in_ready),    32'h1);
    check("rst_out_v", 32'(out_valid),   32'h0);

    in_valid = 1'b1; in_we = 1'b1; in_tag = 5'd1;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'h10 + 32'(k);
      step();
      check("stream_occ", 32'(occ), (k < 3) ? 32'(k + 1) : 32'd4);
      if (k >= 3) begin
        check("stream_out_v", 32'(out_valid), 32'h1);
        check("stream_out_d", out_data, 32'h10 + 32'(k - 3));
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("drain_out_d", out_data, 32'h13 + 32'(k));
    end

    // ---------------- stall on stage 2 ----------------
    do_reset();
    for (int k = 0; k < 4; k++) push(32'h20 + 32'(k), 5'd2, 1'b1);
    in_data = 32'h24;
    stall   = 4'b0100;
    #1;
    check("stall_ready0", 32'(in_ready), 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_out_v", 32'(out_valid),   32'h0);
      check("stall_valid", 32'(stage_valid), 32'h7);
      check("stall_s2",    stage_data[2*WIDTH +: WIDTH], 32'h21);
      check("stall_s0",    stage_data[0*WIDTH +: WIDTH], 32'h23);
      check("stall_occ",   32'(occ),         32'h3);
      check("stall_ready", 32'(in_ready),    32'h0);
    end
    stall = '0;
    #1;
    check("unstall_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      in_data = 32'h25 + 32'(k);
      check("unstall_out_v", 32'(out_valid), 32'h1);
      check("unstall_out_d", out_data, 32'h21 + 32'(k));
    end

    // ---------------- stall + clear on stage 2 ----------------
    do_reset();
    for (int k = 0; k < 4; k++) push(32'h30 + 32'(k), 5'd3, 1'b1);
    in_data = 32'h34;
    stall   = 4'b0100;
    clear   = 4'b0100;
    step();
    check("clr_valid", 32'(stage_valid), 32'h3);
    check("clr_flush", 32'(flush_cnt),   32'h1);
    check("clr_occ",   32'(occ),         32'h2);
    check("clr_s0",    stage_data[0*WIDTH +: WIDTH], 32'h33);
    check("clr_s1",    stage_data[1*WIDTH +: WIDTH], 32'h32);
    check("clr_s2",    stage_data[2*WIDTH +: WIDTH], 32'h0);
    stall = '0;
    clear = '0;
    step();
    check("clr_after_s2",    stage_data[2*WIDTH +: WIDTH], 32'h32);
    check("clr_after_flush", 32'(flush_cnt), 32'h1);

    // ---------------- forwarding ----------------
    do_reset();
    push(32'hBBBB, 5'd5, 1'b1);
    push(32'h1111, 5'd7, 1'b1);
    push(32'hAAAA, 5'd5, 1'b1);
    push(32'h2222, 5'd7, 1'b1);
    in_valid = 1'b0;
    stall    = 4'b1000;
    q_addr   = 5'd5;
    #1;
    check("fwd5_hit",   32'(q_hit),   32'h1);
    check("fwd5_data",  q_data,       32'hAAAA);
    check("fwd5_stage", 32'(q_stage), 32'h1);
    q_addr = 5'd0;
    #1;
    check("fwd0_hit",   32'(q_hit),   32'h0);
    check("fwd0_data",  q_data,       32'h0);
    check("fwd0_stage", 32'(q_stage), 32'h0);
    q_addr = 5'd7;
    #1;
    check("fwd7_data",  q_data,       32'h2222);
    check("fwd7_stage", 32'(q_stage), 32'h0);
    q_addr = 5'd9;
    #1;
    check("fwd9_hit",   32'(q_hit),   32'h0);
    step();
    check("freeze_occ",   32'(occ),         32'h4);
    check("freeze_valid", 32'(stage_valid), 32'hF);

    do_reset();
    push(32'hBBBB, 5'd5, 1'b1);
    push(32'h1111, 5'd7, 1'b1);
    push(32'hAAAA, 5'd5, 1'b0);
    push(32'h2222, 5'd7, 1'b1);
    in_valid = 1'b0;
    stall    = 4'b1000;
    q_addr   = 5'd5;
    #1;
    check("fwdwe_stage_we", 32'(stage_we), 32'hD);
    check("fwdwe_hit",      32'(q_hit),    32'h1);
    check("fwdwe_data",     q_data,        32'hBBBB);
    check("fwdwe_stage",    32'(q_stage),  32'h3);

    // ---------------- async reset mid-stream ----------------
    do_reset();
    push(32'h40, 5'd1, 1'b1);
    push(32'h41, 5'd1, 1'b1);
    clear = 4'b0001;
    push(32'h42, 5'd1, 1'b1);
    clear = '0;
    step();
    q_addr = 5'd1;
    #1;
    check("pre_arst_flush", 32'(flush_cnt), 32'h1);
    check("pre_arst_hit",   32'(q_hit),     32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(stage_valid), 32'h0);
    check("arst_occ",   32'(occ),         32'h0);
    check("arst_flush", 32'(flush_cnt),   32'h0);
    check("arst_hit",   32'(q_hit),       32'h0);
    step();
    reset = 1'b1;

    // ---------------- flush counter saturation ----------------
    do_reset();
    push(32'h50, 5'd2, 1'b1);
    in_valid = 1'b0;
    step();
    push(32'h51, 5'd2, 1'b1);
    check("sat_start_valid", 32'(stage_valid), 32'h5);
    check("sat_start_flush", 32'(flush_cnt),   32'h0);
    for (int n = 0; n < 32767; n++) begin
      clear = ((n % 2) == 0) ? 4'b0101 : 4'b1010;
      step();
    end
    check("sat_fffe",  32'(flush_cnt),   32'hFFFE);
    check("sat_valid", 32'(stage_valid), 32'hA);
    clear = 4'b1010;
    step();
    check("sat_ffff", 32'(flush_cnt), 32'hFFFF);
    clear = 4'b0101;
    step();
    check("sat_hold", 32'(flush_cnt), 32'hFFFF);
    clear = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
